// File: rtl/cnn_layer_accel_FAS_pkg.sv
// cnn_layer_accel_FAS_pkg: shared vec-add mode/state encodings and source-requirement helpers
package cnn_layer_accel_FAS_pkg;
  typedef enum logic [2:0] {
    MODE_NONE    = 3'd0,
    MODE_PM      = 3'd1,
    MODE_RM0     = 3'd2,
    MODE_PM_RM1  = 3'd3,
    MODE_RM_CONV = 3'd4,
    MODE_PV      = 3'd5
  } vec_add_mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_REUSE, ST_DONE} vec_add_state_e;
  typedef struct packed {
    logic conv;
    logic part;
    logic resd;
    logic prev;
    logic dwc;
  } src_t;
  function automatic src_t src_need(input vec_add_mode_e m);
    return '{
      conv: m inside {MODE_PM, MODE_RM0, MODE_PM_RM1},
      part: m inside {MODE_PM, MODE_PM_RM1},
      resd: m inside {MODE_RM0, MODE_PM_RM1, MODE_RM_CONV},
      prev: m == MODE_PV,
      dwc:  m inside {MODE_RM_CONV, MODE_PV}
    };
  endfunction
  function automatic logic mode_valid(input logic [2:0] m);
    return m inside {MODE_PM, MODE_RM0, MODE_PM_RM1, MODE_RM_CONV, MODE_PV};
  endfunction
  // modes whose conv/part/resd operands stay resident in the sum array after pass 0
  function automatic logic mode_reuse(input vec_add_mode_e m);
    return m inside {MODE_PM, MODE_RM0, MODE_PM_RM1};
  endfunction
endpackage

// File: rtl/cnn_layer_accel_fas_vec_add_ctrl_if.sv
// cnn_layer_accel_fas_vec_add_ctrl_if: job/config, source-FIFO, strobe and status bundle of the vec-add controller
// master: job issuer / FIFO + consumer side; slave: the controller.
// stall_cnt exists only when FAS_VEC_ADD_CTRL_STALL_CNT_EN is defined.
interface cnn_layer_accel_fas_vec_add_ctrl_if #(parameter int C_CFG_WTH = 16);
  logic                 start;
  logic [2:0]           vec_add_mode_cfg;
  logic [C_CFG_WTH-1:0] krnl1x1_dpth_end_cfg;
  logic [C_CFG_WTH-1:0] krnl1x1_num_end_cfg;
  logic                 convMap_fifo_empty, partMap_fifo_empty, resdMap_fifo_empty, prevMap_fifo_empty, conv1x1_dwc_fifo_empty;
  logic                 downstream_rdy;
  logic                 convMap_fifo_rd_en, partMap_fifo_rd_en, resdMap_fifo_rd_en, prevMap_fifo_rd_en, conv1x1_dwc_fifo_rd_en;
  logic                 vector_add_pm, vector_add_rm0, vector_add_rm1, vector_add_rm_conv, vector_add_pv;
  logic                 pipe_enable, sum_vld, busy, process_cmpl;
`ifdef FAS_VEC_ADD_CTRL_STALL_CNT_EN
  logic [31:0]          stall_cnt;
`endif
  modport master (
    output start, vec_add_mode_cfg, krnl1x1_dpth_end_cfg, krnl1x1_num_end_cfg,
    output convMap_fifo_empty, partMap_fifo_empty, resdMap_fifo_empty, prevMap_fifo_empty, conv1x1_dwc_fifo_empty, downstream_rdy,
    input  convMap_fifo_rd_en, partMap_fifo_rd_en, resdMap_fifo_rd_en, prevMap_fifo_rd_en, conv1x1_dwc_fifo_rd_en,
    input  vector_add_pm, vector_add_rm0, vector_add_rm1, vector_add_rm_conv, vector_add_pv,
    input  pipe_enable, sum_vld, busy, process_cmpl
`ifdef FAS_VEC_ADD_CTRL_STALL_CNT_EN
    , input stall_cnt
`endif
  );
  modport slave (
    input  start, vec_add_mode_cfg, krnl1x1_dpth_end_cfg, krnl1x1_num_end_cfg,
    input  convMap_fifo_empty, partMap_fifo_empty, resdMap_fifo_empty, prevMap_fifo_empty, conv1x1_dwc_fifo_empty, downstream_rdy,
    output convMap_fifo_rd_en, partMap_fifo_rd_en, resdMap_fifo_rd_en, prevMap_fifo_rd_en, conv1x1_dwc_fifo_rd_en,
    output vector_add_pm, vector_add_rm0, vector_add_rm1, vector_add_rm_conv, vector_add_pv,
    output pipe_enable, sum_vld, busy, process_cmpl
`ifdef FAS_VEC_ADD_CTRL_STALL_CNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/cnn_layer_accel_FAS_vec_add_cnt.sv
// cnn_layer_accel_FAS_vec_add_cnt: depth-beat / 1x1-kernel pass counter with wrap and last-pass flags
// clr restarts a job, en advances one depth beat; wrap = this beat ends a pass, last = current pass is the final one.
module cnn_layer_accel_FAS_vec_add_cnt #(parameter int C_CFG_WTH = 16) (
  input  logic                 clk_FAS,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [C_CFG_WTH-1:0] dpth_end,
  input  logic [C_CFG_WTH-1:0] num_end,
  output logic                 wrap,
  output logic                 last
);
  logic [C_CFG_WTH-1:0] dpth, pass;
  assign wrap = en && dpth == dpth_end;
  assign last = pass == num_end;
  always_ff @(posedge clk_FAS or posedge rst)
    if (rst) begin
      dpth <= '0;
      pass <= '0;
    end else if (clr) begin
      dpth <= '0;
      pass <= '0;
    end else if (en) begin
      dpth <= wrap ? '0 : dpth + 1'b1;
      pass <= wrap ? pass + 1'b1 : pass;
    end
endmodule

// File: rtl/cnn_layer_accel_fas_vec_add_ctrl.sv
// cnn_layer_accel_fas_vec_add_ctrl: sequences source-FIFO pops, sum-array strobes and pipe advance for the FAS vector add
// Ports: clk_FAS, rst (async, active-high), bus (slave modport: job config, FIFO empties/pops, strobes, status).
// Optional: FAS_VEC_ADD_CTRL_STALL_CNT_EN adds the saturating stall-cycle counter bus.stall_cnt.
module cnn_layer_accel_fas_vec_add_ctrl
  import cnn_layer_accel_FAS_pkg::*;
#(parameter int C_CFG_WTH = 16) (
  input logic                             clk_FAS,
  input logic                             rst,
  cnn_layer_accel_fas_vec_add_ctrl_if.slave bus
);
  vec_add_state_e       state;
  vec_add_mode_e        mode;
  logic [C_CFG_WTH-1:0] dpth_end, num_end;
  src_t                 need, empty_v;
  logic                 start_go, fill_fire, reuse_fire, fire, wrap, last;
  assign need       = src_need(mode);
  assign empty_v    = {bus.convMap_fifo_empty, bus.partMap_fifo_empty, bus.resdMap_fifo_empty, bus.prevMap_fifo_empty, bus.conv1x1_dwc_fifo_empty};
  assign start_go   = state == ST_IDLE && bus.start;
  assign fill_fire  = state == ST_FILL && ~|(need & empty_v) && bus.downstream_rdy;
  // operands already live in the sum array, so a reuse beat only needs the consumer
  assign reuse_fire = state == ST_REUSE && bus.downstream_rdy;
  assign fire       = fill_fire || reuse_fire;
  assign bus.pipe_enable            = fire;
  assign bus.convMap_fifo_rd_en     = fill_fire && need.conv;
  assign bus.partMap_fifo_rd_en     = fill_fire && need.part;
  assign bus.resdMap_fifo_rd_en     = fill_fire && need.resd;
  assign bus.prevMap_fifo_rd_en     = fill_fire && need.prev;
  assign bus.conv1x1_dwc_fifo_rd_en = fill_fire && need.dwc;
  assign bus.vector_add_pm          = fill_fire && (mode == MODE_PM || mode == MODE_PM_RM1);
  assign bus.vector_add_rm0         = fill_fire && mode == MODE_RM0;
  assign bus.vector_add_rm1         = fill_fire && mode == MODE_PM_RM1;
  assign bus.vector_add_rm_conv     = fill_fire && mode == MODE_RM_CONV;
  assign bus.vector_add_pv          = fill_fire && mode == MODE_PV;
  assign bus.busy                   = state != ST_IDLE;
  cnn_layer_accel_FAS_vec_add_cnt #(.C_CFG_WTH(C_CFG_WTH)) u_cnt (
    .clk_FAS (clk_FAS),
    .rst     (rst),
    .clr     (start_go),
    .en      (fire),
    .dpth_end(dpth_end),
    .num_end (num_end),
    .wrap    (wrap),
    .last    (last)
  );
  always_ff @(posedge clk_FAS or posedge rst)
    if (rst) begin
      state            <= ST_IDLE;
      mode             <= MODE_NONE;
      dpth_end         <= '0;
      num_end          <= '0;
      bus.sum_vld      <= 1'b0;
      bus.process_cmpl <= 1'b0;
    end else begin
      bus.sum_vld      <= fire;
      bus.process_cmpl <= state == ST_DONE;
      case (state)
        ST_IDLE: if (bus.start) begin
          mode     <= vec_add_mode_e'(bus.vec_add_mode_cfg);
          dpth_end <= bus.krnl1x1_dpth_end_cfg;
          num_end  <= bus.krnl1x1_num_end_cfg;
          state    <= mode_valid(bus.vec_add_mode_cfg) ? ST_FILL : ST_DONE;
        end
        ST_FILL:  if (wrap) state <= last ? ST_DONE : mode_reuse(mode) ? ST_REUSE : ST_FILL;
        ST_REUSE: if (wrap && last) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
`ifdef FAS_VEC_ADD_CTRL_STALL_CNT_EN
  always_ff @(posedge clk_FAS or posedge rst)
    if (rst) bus.stall_cnt <= '0;
    else if (start_go) bus.stall_cnt <= '0;
    else if ((state == ST_FILL || state == ST_REUSE) && !fire && bus.stall_cnt != '1) bus.stall_cnt <= bus.stall_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_cnn_layer_accel_fas_vec_add_ctrl.sv
// tb_cnn_layer_accel_fas_vec_add_ctrl: directed self-checking bench for the FAS vec-add controller
module tb_cnn_layer_accel_fas_vec_add_ctrl;
  localparam int C_CONV = 0, C_PART = 1, C_RESD = 2, C_PREV = 3, C_DWC = 4, C_PM = 5, C_RM0 = 6, C_RM1 = 7;
  localparam int C_RMC = 8, C_PV = 9, C_PE = 10, C_SV = 11, C_CMPL = 12, C_BAD = 13;
  logic clk_FAS = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int cmpl_cyc = 0;
  int start_cyc = 0;
  int checks = 0;
  int failures = 0;
  int cnt [14] = '{default: 0};
  int base [14] = '{default: 0};
  logic [13:0] outs;
  cnn_layer_accel_fas_vec_add_ctrl_if #(.C_CFG_WTH(16)) bus ();
  cnn_layer_accel_fas_vec_add_ctrl #(.C_CFG_WTH(16)) dut (.clk_FAS(clk_FAS), .rst(rst), .bus(bus));
  always #5 clk_FAS = ~clk_FAS;
  always @(posedge clk_FAS) cyc <= cyc + 1;
  always @(negedge clk_FAS) begin
    if (bus.convMap_fifo_rd_en) cnt[C_CONV]++;
    if (bus.partMap_fifo_rd_en) cnt[C_PART]++;
    if (bus.resdMap_fifo_rd_en) cnt[C_RESD]++;
    if (bus.prevMap_fifo_rd_en) cnt[C_PREV]++;
    if (bus.conv1x1_dwc_fifo_rd_en) cnt[C_DWC]++;
    if (bus.vector_add_pm) cnt[C_PM]++;
    if (bus.vector_add_rm0) cnt[C_RM0]++;
    if (bus.vector_add_rm1) cnt[C_RM1]++;
    if (bus.vector_add_rm_conv) cnt[C_RMC]++;
    if (bus.vector_add_pv) cnt[C_PV]++;
    if (bus.pipe_enable) cnt[C_PE]++;
    if (bus.sum_vld) cnt[C_SV]++;
    if ((bus.convMap_fifo_rd_en && bus.convMap_fifo_empty) || (bus.partMap_fifo_rd_en && bus.partMap_fifo_empty) ||
        (bus.resdMap_fifo_rd_en && bus.resdMap_fifo_empty) || (bus.prevMap_fifo_rd_en && bus.prevMap_fifo_empty) ||
        (bus.conv1x1_dwc_fifo_rd_en && bus.conv1x1_dwc_fifo_empty) || (bus.pipe_enable && !bus.downstream_rdy)) cnt[C_BAD]++;
    if (bus.process_cmpl) begin
      cnt[C_CMPL]++;
      cmpl_cyc = cyc;
    end
  end
  function automatic int dlt(input int i);
    return cnt[i] - base[i];
  endfunction
  task automatic set_empty(input logic v);
    bus.convMap_fifo_empty = v;
    bus.partMap_fifo_empty = v;
    bus.resdMap_fifo_empty = v;
    bus.prevMap_fifo_empty = v;
    bus.conv1x1_dwc_fifo_empty = v;
  endtask
  task automatic do_start(input logic [2:0] m, input logic [15:0] de, input logic [15:0] ne);
    @(posedge clk_FAS);
    #1;
    base = cnt;
    start_cyc = cyc;
    bus.vec_add_mode_cfg = m;
    bus.krnl1x1_dpth_end_cfg = de;
    bus.krnl1x1_num_end_cfg = ne;
    bus.start = 1'b1;
    @(posedge clk_FAS);
    #1;
    bus.start = 1'b0;
    bus.vec_add_mode_cfg = 3'd0;
    bus.krnl1x1_dpth_end_cfg = 16'd0;
    bus.krnl1x1_num_end_cfg = 16'd0;
  endtask
  task automatic wait_cmpl(input string nm, input int budget);
    for (int i = 0; i < budget && dlt(C_CMPL) == 0; i++) begin
      @(negedge clk_FAS);
      #1;
    end
    checks++; if (dlt(C_CMPL) == 0) begin failures++; $display("FAIL %s_timeout no process_cmpl within %0d cycles", nm, budget); end
  endtask
  task automatic test_reset();
    #2;
    outs = {bus.pipe_enable, bus.sum_vld, bus.process_cmpl, bus.busy, bus.convMap_fifo_rd_en, bus.partMap_fifo_rd_en,
            bus.resdMap_fifo_rd_en, bus.prevMap_fifo_rd_en, bus.conv1x1_dwc_fifo_rd_en, bus.vector_add_pm,
            bus.vector_add_rm0, bus.vector_add_rm1, bus.vector_add_rm_conv, bus.vector_add_pv};
    checks++; if (outs !== 14'd0) begin failures++; $display("FAIL reset_outs got=%b exp=0", outs); end
`ifdef FAS_VEC_ADD_CTRL_STALL_CNT_EN
    checks++; if (bus.stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_cnt); end
`endif
    @(posedge clk_FAS);
    #1;
    rst = 1'b0;
    base = cnt;
    repeat (4) @(negedge clk_FAS);
    #1;
    checks++; if (dlt(C_PE) + dlt(C_SV) + dlt(C_CMPL) !== 0) begin failures++; $display("FAIL release_pulse got=%0d exp=0", dlt(C_PE) + dlt(C_SV) + dlt(C_CMPL)); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL release_busy got=%b exp=0", bus.busy); end
  endtask
  task automatic test_pm();
    set_empty(1'b0);
    bus.downstream_rdy = 1'b1;
    do_start(3'd1, 16'd3, 16'd0);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL pm_busy got=%b exp=1", bus.busy); end
    wait_cmpl("pm", 40);
    checks++; if (cmpl_cyc - start_cyc !== 6) begin failures++; $display("FAIL pm_latency got=%0d exp=6", cmpl_cyc - start_cyc); end
    checks++; if (dlt(C_CONV) !== 4 || dlt(C_PART) !== 4) begin failures++; $display("FAIL pm_pops got=%0d/%0d exp=4/4", dlt(C_CONV), dlt(C_PART)); end
    checks++; if (dlt(C_RESD) + dlt(C_PREV) + dlt(C_DWC) !== 0) begin failures++; $display("FAIL pm_other_pops got=%0d exp=0", dlt(C_RESD) + dlt(C_PREV) + dlt(C_DWC)); end
    checks++; if (dlt(C_PM) !== 4 || dlt(C_RM0) + dlt(C_RM1) + dlt(C_RMC) + dlt(C_PV) !== 0) begin failures++; $display("FAIL pm_strobes got=%0d/%0d exp=4/0", dlt(C_PM), dlt(C_RM0) + dlt(C_RM1) + dlt(C_RMC) + dlt(C_PV)); end
    checks++; if (dlt(C_PE) !== 4 || dlt(C_SV) !== 4) begin failures++; $display("FAIL pm_beats got=%0d/%0d exp=4/4", dlt(C_PE), dlt(C_SV)); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL pm_idle got=%b exp=0", bus.busy); end
  endtask
  task automatic test_pm_rm1();
    do_start(3'd3, 16'd1, 16'd2);
    wait_cmpl("pmrm1", 40);
    checks++; if (cmpl_cyc - start_cyc !== 8) begin failures++; $display("FAIL pmrm1_latency got=%0d exp=8", cmpl_cyc - start_cyc); end
    checks++; if (dlt(C_CONV) !== 2 || dlt(C_PART) !== 2 || dlt(C_RESD) !== 2) begin failures++; $display("FAIL pmrm1_pops got=%0d/%0d/%0d exp=2/2/2", dlt(C_CONV), dlt(C_PART), dlt(C_RESD)); end
    checks++; if (dlt(C_PM) !== 2 || dlt(C_RM1) !== 2 || dlt(C_RM0) !== 0) begin failures++; $display("FAIL pmrm1_strobes got=%0d/%0d/%0d exp=2/2/0", dlt(C_PM), dlt(C_RM1), dlt(C_RM0)); end
    checks++; if (dlt(C_PE) !== 6 || dlt(C_SV) !== 6) begin failures++; $display("FAIL pmrm1_beats got=%0d/%0d exp=6/6", dlt(C_PE), dlt(C_SV)); end
  endtask
  task automatic test_pv_gap();
    bus.convMap_fifo_empty = 1'b1;
    bus.partMap_fifo_empty = 1'b1;
    bus.resdMap_fifo_empty = 1'b1;
    do_start(3'd5, 16'd1, 16'd1);
    @(posedge clk_FAS);
    #1;
    bus.prevMap_fifo_empty = 1'b1;
    repeat (3) @(posedge clk_FAS);
    #1;
    bus.prevMap_fifo_empty = 1'b0;
    wait_cmpl("pv", 40);
    checks++; if (cmpl_cyc - start_cyc !== 9) begin failures++; $display("FAIL pv_latency got=%0d exp=9", cmpl_cyc - start_cyc); end
    checks++; if (dlt(C_PREV) !== 4 || dlt(C_DWC) !== 4 || dlt(C_CONV) !== 0) begin failures++; $display("FAIL pv_pops got=%0d/%0d/%0d exp=4/4/0", dlt(C_PREV), dlt(C_DWC), dlt(C_CONV)); end
    checks++; if (dlt(C_PV) !== 4 || dlt(C_PE) !== 4 || dlt(C_SV) !== 4) begin failures++; $display("FAIL pv_beats got=%0d/%0d/%0d exp=4/4/4", dlt(C_PV), dlt(C_PE), dlt(C_SV)); end
`ifdef FAS_VEC_ADD_CTRL_STALL_CNT_EN
    checks++; if (bus.stall_cnt !== 32'd3) begin failures++; $display("FAIL pv_stall got=%0d exp=3", bus.stall_cnt); end
`endif
    set_empty(1'b0);
  endtask
  task automatic test_rm0_rdy();
    do_start(3'd2, 16'd1, 16'd1);
    @(posedge clk_FAS);
    #1;
    @(posedge clk_FAS);
    #1;
    bus.downstream_rdy = 1'b0;
    repeat (5) @(posedge clk_FAS);
    #1;
    checks++; if (dlt(C_PE) !== 2) begin failures++; $display("FAIL rm0_frozen got=%0d exp=2", dlt(C_PE)); end
    bus.downstream_rdy = 1'b1;
    wait_cmpl("rm0", 40);
    checks++; if (cmpl_cyc - start_cyc !== 11) begin failures++; $display("FAIL rm0_latency got=%0d exp=11", cmpl_cyc - start_cyc); end
    checks++; if (dlt(C_CONV) !== 2 || dlt(C_RESD) !== 2 || dlt(C_RM0) !== 2) begin failures++; $display("FAIL rm0_pops got=%0d/%0d/%0d exp=2/2/2", dlt(C_CONV), dlt(C_RESD), dlt(C_RM0)); end
    checks++; if (dlt(C_PE) !== 4 || dlt(C_SV) !== 4) begin failures++; $display("FAIL rm0_beats got=%0d/%0d exp=4/4", dlt(C_PE), dlt(C_SV)); end
`ifdef FAS_VEC_ADD_CTRL_STALL_CNT_EN
    checks++; if (bus.stall_cnt !== 32'd5) begin failures++; $display("FAIL rm0_stall got=%0d exp=5", bus.stall_cnt); end
`endif
  endtask
  task automatic test_rst_abort();
    do_start(3'd1, 16'd7, 16'd0);
    @(posedge clk_FAS);
    #1;
    @(posedge clk_FAS);
    #1;
    rst = 1'b1;
    #1;
    outs = {bus.pipe_enable, bus.sum_vld, bus.process_cmpl, bus.busy, bus.convMap_fifo_rd_en, bus.partMap_fifo_rd_en,
            bus.resdMap_fifo_rd_en, bus.prevMap_fifo_rd_en, bus.conv1x1_dwc_fifo_rd_en, bus.vector_add_pm,
            bus.vector_add_rm0, bus.vector_add_rm1, bus.vector_add_rm_conv, bus.vector_add_pv};
    checks++; if (outs !== 14'd0) begin failures++; $display("FAIL abort_outs got=%b exp=0", outs); end
    checks++; if (dlt(C_PE) !== 2) begin failures++; $display("FAIL abort_pre_beats got=%0d exp=2", dlt(C_PE)); end
    repeat (2) @(posedge clk_FAS);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk_FAS);
    #1;
    checks++; if (dlt(C_CMPL) !== 0 || bus.busy !== 1'b0) begin failures++; $display("FAIL abort_cmpl got=%0d busy=%b exp=0/0", dlt(C_CMPL), bus.busy); end
    do_start(3'd1, 16'd7, 16'd0);
    wait_cmpl("rerun", 40);
    checks++; if (cmpl_cyc - start_cyc !== 10) begin failures++; $display("FAIL rerun_latency got=%0d exp=10", cmpl_cyc - start_cyc); end
    checks++; if (dlt(C_CONV) !== 8 || dlt(C_PM) !== 8 || dlt(C_SV) !== 8) begin failures++; $display("FAIL rerun_beats got=%0d/%0d/%0d exp=8/8/8", dlt(C_CONV), dlt(C_PM), dlt(C_SV)); end
  endtask
  task automatic test_invalid();
    do_start(3'd7, 16'd3, 16'd0);
    wait_cmpl("inv", 20);
    checks++; if (cmpl_cyc - start_cyc !== 2) begin failures++; $display("FAIL inv_latency got=%0d exp=2", cmpl_cyc - start_cyc); end
    checks++; if (dlt(C_PE) + dlt(C_CONV) + dlt(C_PART) + dlt(C_RESD) + dlt(C_PREV) + dlt(C_DWC) !== 0) begin failures++; $display("FAIL inv_pops got=%0d exp=0", dlt(C_PE) + dlt(C_CONV) + dlt(C_PART)); end
    do_start(3'd0, 16'd3, 16'd0);
    wait_cmpl("none", 20);
    checks++; if (cmpl_cyc - start_cyc !== 2 || dlt(C_PE) !== 0) begin failures++; $display("FAIL none_job got=%0d/%0d exp=2/0", cmpl_cyc - start_cyc, dlt(C_PE)); end
  endtask
  task automatic test_start_busy();
    do_start(3'd1, 16'd3, 16'd0);
    bus.vec_add_mode_cfg = 3'd7;
    bus.start = 1'b1;
    @(posedge clk_FAS);
    #1;
    bus.start = 1'b0;
    wait_cmpl("busy", 40);
    checks++; if (cmpl_cyc - start_cyc !== 6 || dlt(C_PM) !== 4) begin failures++; $display("FAIL busy_ignore got=%0d/%0d exp=6/4", cmpl_cyc - start_cyc, dlt(C_PM)); end
    repeat (3) @(negedge clk_FAS);
    #1;
    checks++; if (dlt(C_CMPL) !== 1 || bus.busy !== 1'b0) begin failures++; $display("FAIL busy_single_cmpl got=%0d busy=%b exp=1/0", dlt(C_CMPL), bus.busy); end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.vec_add_mode_cfg = 3'd0;
    bus.krnl1x1_dpth_end_cfg = 16'd0;
    bus.krnl1x1_num_end_cfg = 16'd0;
    bus.downstream_rdy = 1'b0;
    set_empty(1'b1);
    test_reset();
    test_pm();
    test_pm_rm1();
    test_pv_gap();
    test_rm0_rdy();
    test_rst_abort();
    test_invalid();
    test_start_busy();
    checks++; if (cnt[C_BAD] !== 0) begin failures++; $display("FAIL illegal_pop_or_advance got=%0d exp=0", cnt[C_BAD]); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
